helix4_quad_sched: RTL and testbench
====================================

# helix4_quad_sched

Ordered dispatch/merge scheduler for the four-die Helix4 quad cluster (LookIn, SpiralUp, FlowOut, Return). It takes one upstream user stream and hands each beat to one die, rotating round-robin over an enable mask. It then merges the four per-die action streams back into one output stream in dispatch order, using an internal order FIFO of die tags. It sits between the host-facing stream and the cluster's per-die user/action ports; world ports are not touched.

## Interface
- INPUT_W, helix_pkg::INPUT_W, user beat width
- ACTION_W, helix_pkg::ACTION_W, action beat width
- ORDER_DEPTH, 8, max in-flight beats (order FIFO depth); power of 2, >= 2
- CNT_W, $clog2(ORDER_DEPTH+1), width of in-flight count
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en_mask  in  4  die enable; bit g enables die g as a dispatch target
- in_valid  in  1  upstream user beat valid
- in_ready  out  1  upstream user beat accepted
- in_data  in  INPUT_W  upstream user beat
- die_user_valid  out  4  one-hot valid to die g user port
- die_user_ready  in  4  die g user ready
- die_user_data  out  4xINPUT_W  in_data broadcast to all four dies
- die_action_valid  in  4  die g action valid
- die_action_ready  out  4  die g action ready
- die_action_data  in  4xACTION_W  die g action beat
- out_valid  out  1  merged action valid
- out_ready  in  1  downstream ready
- out_data  out  ACTION_W  merged action beat
- out_die  out  2  index of the die that produced out_data
- inflight  out  CNT_W  order FIFO occupancy
- busy  out  1  inflight != 0

## Operation
- State: ptr (2b), order FIFO (ORDER_DEPTH x 2b die tags, wr/rd pointers), count.
- Target selection: target = first g with en_mask[g]=1, searching ptr, ptr+1, ... (mod 4). It is combinational.
- Dispatch:
  - go = |en_mask && count != ORDER_DEPTH.
  - die_user_valid[target] = in_valid && go; all other bits are 0.
  - in_ready = die_user_ready[target] && go.
  - Fire = in_valid && in_ready. On fire: push target into the FIFO and set ptr <= target+1 (mod 4).
- Merge:
  - head = FIFO head tag when count != 0.
  - out_valid = count != 0 && die_action_valid[head].
  - out_data = die_action_data[head]; out_die = head.
  - die_action_ready[g] = (g == head) && count != 0 && out_ready.
  - Pop on out_valid && out_ready.
- Non-head dies are never made ready. Their action beats stall at the die until they become head, which guarantees output order equals dispatch order.
- Boundaries:
  - en_mask = 0: in_ready=0 and die_user_valid=0. Merge continues to drain.
  - en_mask change: affects future dispatch only. Entries already queued for a now-disabled die still drain normally.
  - FIFO full: in_ready=0, even if a pop occurs in the same cycle (no full-bypass).
  - FIFO empty: out_valid=0 and all die_action_ready=0. An entry pushed this cycle cannot pop until the next cycle (no empty-bypass).
  - Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
  - Pointer wrap at ORDER_DEPTH: modulo, no gap.
- Reset (async assert, any time): ptr=0, FIFO empty, count=0.
  - Outputs during/after reset: out_valid=0, die_action_ready=0, inflight=0, busy=0. die_user_valid/in_ready follow the combinational rules with count=0.
  - Mid-operation reset drops all in-flight tags. The dies share rst_n and are cleared with it.

## Timing
- Dispatch path is combinational, 0 cycles: in_valid → die_user_valid, and die_user_ready → in_ready.
- Merge path is combinational, 0 cycles: die_action_valid[head] → out_valid, and out_ready → die_action_ready[head].
- FIFO push is visible to the merge side one cycle after fire. Minimum dispatch-to-out latency is 1 cycle plus die latency.
- Sustained throughput is 1 beat/cycle each side, provided target dies are ready and count < ORDER_DEPTH.
- With out_ready=0: out_valid, out_data and out_die hold stable while die_action_valid[head] holds.

## Test plan
- Reset: hold rst_n=0 with traffic on all inputs → out_valid=0, inflight=0, busy=0, all die_action_ready=0. Release with en_mask=4'b1111, in_valid=1 → die_user_valid=4'b0001 in the first cycle.
- Round-robin and order: en_mask=4'b1111; send in_data 0x10..0x13 back-to-back → die_user_valid 0001, 0010, 0100, 1000. Dies respond in order die3, die2, die1, die0 → out_die sequence 0,1,2,3 with the matching data; inflight goes 4→0.
- Sparse mask: en_mask=4'b0101; send 4 beats → targets 0,2,0,2. Change mask to 4'b1000 mid-stream → the next beat goes to die 3, and queued die0/die2 entries still drain.
- Full: ORDER_DEPTH=8, out_ready=0, dies always valid; push 8 beats → inflight=8 and in_ready=0 on the 9th. Pulse out_ready one cycle → one pop; in_ready=1 the following cycle.
- Empty mask: en_mask=0 with in_valid=1 → in_ready=0 and die_user_valid=0 for 10 cycles; queued entries still pop.
- Backpressure: out_ready=0 with the head die valid → out_data stable and all die_action_ready=0. Assert rst_n=0 mid-stream → inflight=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/helix4_quad_sched.sv
// helix4_quad_sched
//   Ordered dispatch/merge scheduler for the four-die Helix4 quad cluster.
//   Upstream user beats are handed round-robin to the enabled dies. The
//   per-die action streams are merged back into one output stream in
//   dispatch order, using an order FIFO of 2-bit die tags.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   en_mask[3:0]          die g is a dispatch target when bit g is set
//   in_valid/in_ready     upstream user beat handshake, in_data payload
//   die_user_valid[3:0]   one-hot valid to the selected die
//   die_user_ready[3:0]   per-die user ready
//   die_user_data         in_data broadcast to all four dies (die g at slice g)
//   die_action_valid/ready/data  per-die action stream (die g at slice g)
//   out_valid/out_ready   merged action handshake, out_data payload
//   out_die               die that produced out_data
//   inflight, busy        order FIFO occupancy, occupancy != 0

module helix4_quad_sched #(
   parameter int unsigned INPUT_W     = 16,
   parameter int unsigned ACTION_W    = 16,
   parameter int unsigned ORDER_DEPTH = 8,
   parameter int unsigned CNT_W       = $clog2(ORDER_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            en_mask,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INPUT_W-1:0]    in_data,
   output logic [3:0]            die_user_valid,
   input  logic [3:0]            die_user_ready,
   output logic [4*INPUT_W-1:0]  die_user_data,
   input  logic [3:0]            die_action_valid,
   output logic [3:0]            die_action_ready,
   input  logic [4*ACTION_W-1:0] die_action_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACTION_W-1:0]   out_data,
   output logic [1:0]            out_die,
   output logic [CNT_W-1:0]      inflight,
   output logic                  busy
);

   localparam int unsigned AW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;

   logic [1:0]          ptr;
   logic [1:0]          order_mem [ORDER_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CNT_W-1:0]    count;

   logic [1:0]          target;
   logic [1:0]          cand;
   logic                found;
   logic                go;
   logic                fire;
   logic                pop;
   logic                not_empty;
   logic                full;
   logic [1:0]          head;
   logic [ACTION_W-1:0] act_arr [4];

   for (genvar g = 0; g < 4; g++) begin : g_act
      assign act_arr[g] = die_action_data[g*ACTION_W +: ACTION_W];
   end

   // First enabled die at or after ptr, wrapping modulo 4.
   always_comb begin
      target = ptr;
      cand   = ptr;
      found  = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         cand = ptr + 2'(i);
         if (!found && en_mask[cand]) begin
            target = cand;
            found  = 1'b1;
         end
      end
   end

   assign not_empty = (count != '0);
   // Full blocks dispatch even when a pop happens in the same cycle.
   assign full      = (count == CNT_W'(ORDER_DEPTH));
   assign go        = (|en_mask) && !full;

   assign die_user_valid = (in_valid && go) ? (4'b0001 << target) : 4'b0000;
   assign in_ready       = die_user_ready[target] && go;
   assign die_user_data  = {4{in_data}};
   assign fire           = in_valid && in_ready;

   // Only the head die is ever made ready, which keeps output in dispatch order.
   assign head             = order_mem[rd_ptr];
   assign out_valid        = not_empty && die_action_valid[head];
   assign out_data         = act_arr[head];
   assign out_die          = head;
   assign die_action_ready = (not_empty && out_ready) ? (4'b0001 << head) : 4'b0000;
   assign pop              = out_valid && out_ready;

   assign inflight = count;
   assign busy     = not_empty;

   always_ff @(posedge clk) begin
      if (fire) begin
         order_mem[wr_ptr] <= target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fire) begin
            ptr    <= target + 2'd1;
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({fire, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_helix4_quad_sched.sv
module tb_helix4_quad_sched;

   localparam int IW = 16;
   localparam int AW = 16;
   localparam int D  = 8;
   localparam int CW = $clog2(D + 1);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      en_mask = 4'b1111;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [IW-1:0]   in_data = '0;
   logic [3:0]      die_user_valid;
   logic [3:0]      die_user_ready = '0;
   logic [4*IW-1:0] die_user_data;
   logic [3:0]      die_action_valid = '0;
   logic [3:0]      die_action_ready;
   logic [4*AW-1:0] die_action_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [AW-1:0]   out_data;
   logic [1:0]      out_die;
   logic [CW-1:0]   inflight;
   logic            busy;

   always #5 clk = ~clk;

   helix4_quad_sched #(
      .INPUT_W     (IW),
      .ACTION_W    (AW),
      .ORDER_DEPTH (D),
      .CNT_W       (CW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .en_mask          (en_mask),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .die_user_valid   (die_user_valid),
      .die_user_ready   (die_user_ready),
      .die_user_data    (die_user_data),
      .die_action_valid (die_action_valid),
      .die_action_ready (die_action_ready),
      .die_action_data  (die_action_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_die          (out_die),
      .inflight         (inflight),
      .busy             (busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: dispatch pointer, global order list, per-die work queues.
   int            m_ptr = 0;
   int            ord_die[$];
   logic [IW-1:0] ord_dat[$];
   logic [IW-1:0] die_q [4][$];

   function automatic logic [AW-1:0] xform(input int g, input logic [IW-1:0] d);
      return {d[7:0], d[15:8]} ^ (16'h1001 << g);
   endfunction

   task automatic drive_dies();
      for (int g = 0; g < 4; g++) begin
         if (die_q[g].size() > 0) begin
            die_action_valid[g] = ($urandom % 4) != 0;
            die_action_data[g*AW +: AW] = xform(g, die_q[g][0]);
         end else begin
            die_action_valid[g] = 1'b0;
            die_action_data[g*AW +: AW] = AW'($urandom);
         end
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      ord_die.delete();
      ord_dat.delete();
      for (int g = 0; g < 4; g++) die_q[g].delete();
   endtask

   // One clock cycle: randomise inputs, check combinational outputs mid-cycle,
   // then advance the model by what should have fired at the edge.
   task automatic step(input int p_or, input int p_iv, input int empty_mask);
      int cnt, tgt, hd;
      logic go, exp_ir, exp_ov, fire, pop;
      logic [3:0] exp_uv, exp_ar;
      logic [IW-1:0] dat;
      in_valid = ($urandom % 100) < p_iv;
      in_data  = IW'($urandom);
      for (int g = 0; g < 4; g++) die_user_ready[g] = ($urandom % 5) != 0;
      out_ready = ($urandom % 100) < p_or;
      if (empty_mask != 0) en_mask = 4'b0000;
      else if (($urandom % 8) == 0 || en_mask == 4'b0000) en_mask = 4'($urandom_range(1, 15));
      drive_dies();
      @(negedge clk);
      cnt = ord_die.size();
      tgt = -1;
      for (int i = 0; i < 4; i++) begin
         if (tgt < 0 && en_mask[(m_ptr + i) % 4]) tgt = (m_ptr + i) % 4;
      end
      go     = (tgt >= 0) && (cnt < D);
      exp_uv = (in_valid && go) ? 4'(1 << tgt) : 4'b0000;
      exp_ir = go && die_user_ready[tgt < 0 ? 0 : tgt];
      hd     = (cnt > 0) ? ord_die[0] : 0;
      exp_ov = (cnt > 0) && die_action_valid[hd];
      exp_ar = (cnt > 0 && out_ready) ? 4'(1 << hd) : 4'b0000;
      check("die_user_valid", 32'(die_user_valid), 32'(exp_uv));
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("die_action_ready", 32'(die_action_ready), 32'(exp_ar));
      check("inflight", 32'(inflight), 32'(cnt));
      check("busy", 32'(busy), 32'(cnt > 0));
      if (exp_ov) begin
         check("out_die", 32'(out_die), 32'(hd));
         check("out_data", 32'(out_data), 32'(xform(hd, ord_dat[0])));
      end
      if (($urandom % 16) == 0)
         check("die_user_data", 32'(die_user_data[($urandom % 4)*IW +: IW]), 32'(in_data));
      fire = in_valid && exp_ir;
      pop  = exp_ov && out_ready;
      dat  = in_data;
      @(posedge clk);
      #1;
      if (pop) begin
         void'(ord_die.pop_front());
         void'(ord_dat.pop_front());
         void'(die_q[hd].pop_front());
      end
      if (fire) begin
         ord_die.push_back(tgt);
         ord_dat.push_back(dat);
         die_q[tgt].push_back(dat);
         m_ptr = (tgt + 1) % 4;
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_inflight"}, 32'(inflight), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_action_ready"}, 32'(die_action_ready), 32'd0);
   endtask

   initial begin
      // Reset held with traffic on all inputs.
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data = IW'($urandom);
         die_user_ready = 4'($urandom);
         die_action_valid = 4'b1111;
         die_action_data = {4{16'($urandom)}};
         out_ready = 1'b1;
         en_mask = 4'($urandom);
         @(negedge clk);
         reset_checks("rst_hold");
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en_mask = 4'b1111;
      in_valid = 1'b1;
      die_user_ready = 4'b1111;
      die_action_valid = 4'b0000;
      #1;
      check("first_target", 32'(die_user_valid), 32'h1);
      check("first_in_ready", 32'(in_ready), 32'h1);

      // General mixed traffic.
      for (int c = 0; c < 600; c++) step(60, 75, 0);
      // Starved output: drives the order FIFO to full.
      for (int c = 0; c < 200; c++) step(8, 90, 0);
      // Empty mask: nothing dispatched, queue keeps draining.
      for (int c = 0; c < 10; c++) step(70, 100, 1);
      // Fast drain and refill.
      for (int c = 0; c < 400; c++) step(95, 95, 0);

      // Mid-stream reset while entries are queued.
      for (int c = 0; c < 40; c++) step(5, 95, 0);
      rst_n = 1'b0;
      #1;
      reset_checks("mid_rst");
      model_reset();
      drive_dies();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 600; c++) step(50, 80, 0);
      for (int c = 0; c < 100; c++) step(15, 90, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
